// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared constants and types for the ALU issue buffer.
//   ALU_* select codes, major opcode constants (instruction bits [6:2]),
//   branch funct3 codes, buffer state encoding and the stored entry layout.
package alu_issue_pkg;

  // ALU_ADD is zero so that an empty buffer presents an all-zero select.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_PASS = 4'd10
  } alu_sel_e;

  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } fifo_state_e;

  typedef struct packed {
    alu_sel_e    sel;
    logic        illegal;
    logic [4:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] op1;
    logic [31:0] op2;
  } entry_t;

endpackage

// File: rtl/alu_issue_sel_decode.sv
// alu_sel_decode: combinational decode of opcode/funct3/funct7_5 into an
// ALU select plus an illegal-instruction flag.
//   opcode_i   [4:0] instruction bits [6:2]
//   funct3_i   [2:0] instruction bits [14:12]
//   funct7_5_i       instruction bit  [30]
//   sel_o            ALU select code
//   illegal_o        unrecognised opcode (or, with BRANCH_EVAL_EN defined,
//                    a reserved branch funct3)
module alu_sel_decode
  import alu_issue_pkg::*;
(
  input  logic [4:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output alu_sel_e   sel_o,
  output logic       illegal_o
);

  always_comb begin
    sel_o     = ALU_ADD;
    illegal_o = 1'b0;
    case (opcode_i)
      OPC_OP, OPC_OP_IMM: begin
        case (funct3_i)
          // Immediate forms have no SUB; bit 30 is part of the immediate.
          3'b000:  sel_o = (funct7_5_i && opcode_i == OPC_OP) ? ALU_SUB : ALU_ADD;
          3'b001:  sel_o = ALU_SLL;
          3'b010:  sel_o = ALU_SLT;
          3'b011:  sel_o = ALU_SLTU;
          3'b100:  sel_o = ALU_XOR;
          3'b101:  sel_o = funct7_5_i ? ALU_SRA : ALU_SRL;
          3'b110:  sel_o = ALU_OR;
          default: sel_o = ALU_AND;
        endcase
      end
      OPC_LUI: sel_o = ALU_PASS;
      OPC_AUIPC, OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR: sel_o = ALU_ADD;
      OPC_BRANCH: begin
        sel_o = ALU_SUB;
`ifdef BRANCH_EVAL_EN
        illegal_o = (funct3_i == 3'b010) || (funct3_i == 3'b011);
`endif
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: two-entry skid buffer between operand resolution and the ALU.
// Instructions are decoded on entry; the head entry drives the ALU inputs.
// Optional macro BRANCH_EVAL_EN enables branch evaluation from ALU flags.
//   clk, rst_n, flush                      clock, async low reset, sync discard
//   in_valid/in_ready, in_opcode, in_funct3,
//   in_funct7_5, in_op1, in_op2            upstream handshake and payload
//   out_valid/out_ready                    downstream handshake
//   alu_sel, alu_in1, alu_in2, alu_shamt,
//   alu_opcode, alu_funct3, illegal        head entry (zeros when empty)
//   zero/sign/ovf/carry_flag               ALU flags for the head entry
//   br_taken                               branch decision for the head entry
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic        in_funct7_5,
  input  logic [31:0] in_op1,
  input  logic [31:0] in_op2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_sel,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [4:0]  alu_shamt,
  output logic [4:0]  alu_opcode,
  output logic [2:0]  alu_funct3,
  output logic        illegal,
  input  logic        zero_flag,
  input  logic        sign_flag,
  input  logic        ovf_flag,
  input  logic        carry_flag,
  output logic        br_taken
);

  fifo_state_e state_q, state_d;
  entry_t      mem_q [2];
  entry_t      new_entry, head;
  logic        rd_ptr_q, wr_ptr_q;
  logic        ready_q;
  logic        push, pop;
  alu_sel_e    dec_sel;
  logic        dec_illegal;

  alu_sel_decode u_dec (
    .opcode_i   (in_opcode),
    .funct3_i   (in_funct3),
    .funct7_5_i (in_funct7_5),
    .sel_o      (dec_sel),
    .illegal_o  (dec_illegal)
  );

  // ready_q keeps in_ready low during reset and until the first clock edge.
  assign in_ready  = ready_q && (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign new_entry = '{sel: dec_sel, illegal: dec_illegal, opcode: in_opcode,
                       funct3: in_funct3, op1: in_op1, op2: in_op2};

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (push) state_d = ST_ONE;
      ST_ONE: begin
        if (push && !pop)      state_d = ST_FULL;
        else if (pop && !push) state_d = ST_EMPTY;
      end
      ST_FULL:  if (pop) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      if (flush) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= ~wr_ptr_q;
        if (pop)  rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // Payload storage needs no reset: every output is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= new_entry;
  end

  assign head       = mem_q[rd_ptr_q];
  assign alu_sel    = out_valid ? head.sel     : ALU_ADD;
  assign alu_in1    = out_valid ? head.op1     : 32'd0;
  assign alu_in2    = out_valid ? head.op2     : 32'd0;
  assign alu_shamt  = out_valid ? head.op2[4:0] : 5'd0;
  assign alu_opcode = out_valid ? head.opcode  : 5'd0;
  assign alu_funct3 = out_valid ? head.funct3  : 3'd0;
  assign illegal    = out_valid && head.illegal;

`ifdef BRANCH_EVAL_EN
  logic br_cond;

  always_comb begin
    br_cond = 1'b0;
    case (head.funct3)
      BR_EQ:   br_cond = zero_flag;
      BR_NE:   br_cond = !zero_flag;
      BR_LT:   br_cond = (sign_flag != ovf_flag);
      BR_GE:   br_cond = (sign_flag == ovf_flag);
      BR_LTU:  br_cond = !carry_flag;
      BR_GEU:  br_cond = carry_flag;
      default: br_cond = 1'b0;
    endcase
  end

  assign br_taken = out_valid && (head.opcode == OPC_BRANCH) && br_cond;
`else
  logic unused_flags;
  assign unused_flags = ^{zero_flag, sign_flag, ovf_flag, carry_flag};
  assign br_taken     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic        clk, rst_n, flush, in_valid, in_ready, in_funct7_5;
  logic [4:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [31:0] in_op1, in_op2;
  logic        out_valid, out_ready, illegal, br_taken;
  logic [3:0]  alu_sel;
  logic [31:0] alu_in1, alu_in2;
  logic [4:0]  alu_shamt, alu_opcode;
  logic [2:0]  alu_funct3;
  logic        zero_flag, sign_flag, ovf_flag, carry_flag;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
    .in_op1(in_op1), .in_op2(in_op2),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_sel(alu_sel), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_shamt(alu_shamt), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3),
    .illegal(illegal),
    .zero_flag(zero_flag), .sign_flag(sign_flag), .ovf_flag(ovf_flag),
    .carry_flag(carry_flag), .br_taken(br_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sel;
    logic        ill;
    logic [4:0]  opc;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   chk_en = 0;
  bit   pushed_now = 0;
  int   rdy_mode = 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endfunction

  // Reference decode written from the instruction-set rules.
  function automatic exp_t model(logic [4:0] opc, logic [2:0] f3, logic f7,
                                 logic [31:0] a, logic [31:0] b);
    exp_t e;
    logic [3:0] tab [8];
    tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    e.opc = opc; e.f3 = f3; e.a = a; e.b = b;
    e.sel = ALU_ADD; e.ill = 1'b0;
    if (opc == 5'b01100 || opc == 5'b00100) begin
      e.sel = tab[f3];
      if (f7 && f3 == 3'd5) e.sel = ALU_SRA;
      if (f7 && f3 == 3'd0 && opc == 5'b01100) e.sel = ALU_SUB;
    end else if (opc == 5'b01101) begin
      e.sel = ALU_PASS;
    end else if (opc inside {5'b00101, 5'b00000, 5'b01000, 5'b11011, 5'b11001}) begin
      e.sel = ALU_ADD;
    end else if (opc == 5'b11000) begin
      e.sel = ALU_SUB;
`ifdef BRANCH_EVAL_EN
      e.ill = (f3 == 3'd2 || f3 == 3'd3);
`endif
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  // Branch outcome from a direct comparison of the operands.
  function automatic logic br_model(exp_t e);
`ifdef BRANCH_EVAL_EN
    if (e.opc != 5'b11000) return 1'b0;
    case (e.f3)
      3'd0: return e.a == e.b;
      3'd1: return e.a != e.b;
      3'd4: return $signed(e.a) <  $signed(e.b);
      3'd5: return $signed(e.a) >= $signed(e.b);
      3'd6: return e.a <  e.b;
      3'd7: return e.a >= e.b;
      default: return 1'b0;
    endcase
`else
    return 1'b0;
`endif
  endfunction

  // Behavioural ALU: flags from head operands a - b.
  always @(posedge clk) begin
    logic [31:0] a, b, d;
    #2;
    if (q.size() > 0) begin
      a = q[0].a; b = q[0].b; d = a - b;
      zero_flag  = (a == b);
      sign_flag  = d[31];
      ovf_flag   = (a[31] != b[31]) && (d[31] != a[31]);
      carry_flag = (a >= b);
    end else begin
      {zero_flag, sign_flag, ovf_flag, carry_flag} = 4'($urandom_range(0, 15));
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    int   occ;
    exp_t e;
    #1;
    if (chk_en && rst_n) begin
      occ = q.size() - (pushed_now ? 1 : 0);
      check("out_valid", out_valid, occ > 0);
      check("in_ready", in_ready, occ < 2);
      if (occ > 0) begin
        e = q[0];
        check("alu_sel", alu_sel, e.sel);
        check("illegal", illegal, e.ill);
        check("alu_opcode", alu_opcode, e.opc);
        check("alu_funct3", alu_funct3, e.f3);
        check("alu_in1", alu_in1, e.a);
        check("alu_in2", alu_in2, e.b);
        check("alu_shamt", alu_shamt, e.b[4:0]);
        check("br_taken", br_taken, br_model(e));
        if (out_ready && !flush) void'(q.pop_front());
      end else begin
        check("empty_outputs", {alu_sel, alu_in1, alu_in2, alu_shamt, alu_opcode,
                                alu_funct3, illegal, br_taken}, 64'd0);
      end
    end
  end

  task automatic send(logic [4:0] opc, logic [2:0] f3, logic f7,
                      logic [31:0] a, logic [31:0] b);
    bit acc = 0;
    in_valid = 1'b1; in_opcode = opc; in_funct3 = f3; in_funct7_5 = f7;
    in_op1 = a; in_op2 = b;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      acc = in_ready && !flush;
      if (acc) begin
        q.push_back(model(opc, f3, f7, a, b));
        pushed_now = 1;
      end
      @(posedge clk);
      pushed_now = 0;
      #1;
      if (acc) break;
    end
    if (!acc) check("accept_timeout", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_flush(bit with_valid);
    flush = 1'b1; in_valid = with_valid;
    in_opcode = 5'b01100; in_op1 = $urandom; in_op2 = $urandom;
    @(negedge clk);
    @(posedge clk);
    q.delete();
    #1;
    flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_data"}, {alu_sel, alu_in1, alu_in2, alu_shamt, alu_opcode,
                           alu_funct3, illegal, br_taken}, 64'd0);
  endtask

  task automatic rand_send();
    logic [4:0]  opcs [10];
    logic [4:0]  opc;
    logic [31:0] a, b;
    opcs = '{5'b01100, 5'b00100, 5'b01101, 5'b00101, 5'b00000,
             5'b01000, 5'b11011, 5'b11001, 5'b11000, 5'b11000};
    opc = ($urandom_range(0, 10) == 10) ? 5'($urandom) : opcs[$urandom_range(0, 9)];
    a = $urandom;
    case ($urandom_range(0, 3))
      0:       b = a;
      1:       b = 32'($urandom_range(0, 64));
      default: b = $urandom;
    endcase
    send(opc, 3'($urandom), 1'($urandom), a, b);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_funct3 = '0; in_funct7_5 = 1'b0; in_op1 = '0; in_op2 = '0;
    {zero_flag, sign_flag, ovf_flag, carry_flag} = '0;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", in_ready, 1);
    chk_en = 1;

    // SUB decode, latency 1
    rdy_mode = 1;
    send(5'b01100, 3'd0, 1'b1, 32'd5, 32'd7);
    idle(2);

    // Back-pressure: third push blocked until the ALU side drains
    rdy_mode = 0;
    idle(1);
    send(5'b01100, 3'd4, 1'b0, 32'h11, 32'h22);
    send(5'b00100, 3'd6, 1'b0, 32'h33, 32'h44);
    fork
      send(5'b01100, 3'd7, 1'b0, 32'h55, 32'h66);
      begin
        @(negedge clk); #2;
        check("third_blocked", in_ready, 0);
        repeat (3) @(posedge clk);
        #1 rdy_mode = 1;
      end
    join
    idle(3);

    // Shift amount, LUI, unknown opcode
    send(5'b00100, 3'd5, 1'b1, 32'h1234, 32'h0000041F);
    send(5'b01101, 3'd0, 1'b0, 32'h0, 32'hABCDE000);
    send(5'b11111, 3'd2, 1'b1, 32'h9, 32'h8);

    // Branches
    send(5'b11000, 3'd4, 1'b0, 32'hFFFF_FFFF, 32'd1);
    send(5'b11000, 3'd7, 1'b0, 32'd1, 32'd2);
    send(5'b11000, 3'd2, 1'b0, 32'd3, 32'd3);
    send(5'b11000, 3'd0, 1'b0, 32'd3, 32'd3);
    idle(3);

    // Flush while FULL with a simultaneous push
    rdy_mode = 0;
    idle(1);
    send(5'b01100, 3'd1, 1'b0, 32'hA, 32'hB);
    send(5'b01100, 3'd2, 1'b0, 32'hC, 32'hD);
    do_flush(1'b1);
    idle(2);
    rdy_mode = 1;
    idle(1);

    // Randomised traffic with back-pressure and occasional flushes
    rdy_mode = 2;
    for (int i = 0; i < 800; i++) begin
      int r;
      r = $urandom_range(0, 39);
      if (r == 0)     do_flush(1'($urandom));
      else if (r < 6) idle(1);
      else            rand_send();
    end

    // Asynchronous reset mid-stream
    rdy_mode = 0;
    idle(1);
    send(5'b01100, 3'd3, 1'b0, 32'h77, 32'h88);
    send(5'b00100, 3'd1, 1'b0, 32'h99, 32'h1F);
    @(negedge clk); #3;
    chk_en = 0;
    rst_n = 1'b0;
    q.delete();
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk); #1;
    check_reset_outputs("held_reset");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rerun", in_ready, 1);
    chk_en = 1;
    rdy_mode = 1;
    send(5'b01100, 3'd0, 1'b0, 32'd40, 32'd2);
    send(5'b11011, 3'd0, 1'b0, 32'h100, 32'h4);

    for (int t = 0; t < 50 && q.size() > 0; t++) idle(1);
    check("drain", q.size(), 0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
